// File: rtl/piso_serializer.sv
// Parallel-in serial-out frame serializer with valid/ready load and back-to-back frames.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(FrameLen);
  localparam logic [CntW-1:0] CntInit = CntW'(FrameLen - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              last_bit, accept, head_bit, cur_bit;

  assign last_bit   = (state_q == StShift) && (cnt_q == '0);
  assign load_ready = (state_q == StIdle) || last_bit;
  assign accept     = load_valid && load_ready;
  assign head_bit   = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  // The parity bit rides in its own flop so the data shifter needs no extra stage.
  assign cur_bit = last_bit ? par_q : head_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = ^d;
    end
  end
`else
  assign cur_bit = head_bit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CntW'(1);
          shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        end else begin
          state_d = StIdle;
          shift_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    // A load on the last-bit cycle overrides the return to idle.
    if (accept) begin
      state_d = StShift;
      shift_d = d;
      cnt_d   = CntInit;
      first_d = 1'b1;
    end
  end

  always_comb begin
    busy        = (state_q == StShift);
    sout_valid  = (state_q == StShift);
    sout        = (state_q == StShift) && cur_bit;
    frame_start = (state_q == StShift) && first_q;
    frame_done  = last_bit;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a frame scoreboard.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = 5;
`else
  localparam int unsigned FrameLen = 4;
`endif

  logic       clk, reset, load_valid;
  logic [3:0] d;
  logic       ready_m, sout_m, valid_m, start_m, done_m, busy_m;
  logic       ready_l, sout_l, valid_l, start_l, done_l, busy_l;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .d(d), .load_valid(load_valid), .load_ready(ready_m),
    .sout(sout_m), .sout_valid(valid_m), .frame_start(start_m), .frame_done(done_m),
    .busy(busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .d(d), .load_valid(load_valid), .load_ready(ready_l),
    .sout(sout_l), .sout_valid(valid_l), .frame_start(start_l), .frame_done(done_l),
    .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic sm;
    logic sl;
    logic st;
    logic dn;
  } rec_t;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] exp_m;
    logic [3:0] exp_l;
    logic       exp_par;
  } vec_t;

  rec_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;
  logic m_rdy;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] w);
    rec_t r;
    for (int i = 0; i < 4; i++) begin
      r.sm = w[3-i];
      r.sl = w[i];
      r.st = (i == 0);
      r.dn = (i == int'(FrameLen) - 1);
      exp_q.push_back(r);
    end
`ifdef PISO_PARITY_EN
    r.sm = ^w;
    r.sl = ^w;
    r.st = 1'b0;
    r.dn = 1'b1;
    exp_q.push_back(r);
`endif
  endtask

  // Reference model: one queue entry per expected serial cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_rdy = (exp_q.size() <= 1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (load_valid && m_rdy) push_frame(d);
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      rec_t r;
      logic ev;
      ev = (exp_q.size() != 0);
      r  = ev ? exp_q[0] : '0;
      chk("sb_sout_m", sout_m, r.sm);
      chk("sb_sout_l", sout_l, r.sl);
      chk("sb_valid_m", valid_m, ev);
      chk("sb_valid_l", valid_l, ev);
      chk("sb_busy_m", busy_m, ev);
      chk("sb_busy_l", busy_l, ev);
      chk("sb_start_m", start_m, r.st);
      chk("sb_start_l", start_l, r.st);
      chk("sb_done_m", done_m, r.dn);
      chk("sb_done_l", done_l, r.dn);
      chk("sb_ready_m", ready_m, exp_q.size() <= 1);
      chk("sb_ready_l", ready_l, exp_q.size() <= 1);
    end
  end

  task automatic outputs_zero(input string nm);
    chk({nm, "_sout"}, {sout_m, sout_l}, 2'b00);
    chk({nm, "_valid"}, {valid_m, valid_l}, 2'b00);
    chk({nm, "_busy"}, {busy_m, busy_l}, 2'b00);
    chk({nm, "_start"}, {start_m, start_l}, 2'b00);
    chk({nm, "_done"}, {done_m, done_l}, 2'b00);
  endtask

  task automatic single_frame(input vec_t v);
    logic [FrameLen-1:0] got_m, got_l;
    @(negedge clk);
    d          = v.d;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    d          = 4'($urandom);
    for (int b = 0; b < int'(FrameLen); b++) begin
      if (b > 0) @(negedge clk);
      got_m[FrameLen-1-b] = sout_m;
      got_l[FrameLen-1-b] = sout_l;
    end
    chk("tbl_stream_m", got_m[FrameLen-1 -: 4], v.exp_m);
    chk("tbl_stream_l", got_l[FrameLen-1 -: 4], v.exp_l);
`ifdef PISO_PARITY_EN
    chk("tbl_parity_m", got_m[0], v.exp_par);
    chk("tbl_parity_l", got_l[0], v.exp_par);
`endif
    @(negedge clk);
    chk("tbl_gap_valid", {valid_m, valid_l}, 2'b00);
  endtask

  task automatic two_frames(input string nm, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [2*FrameLen-1:0] exp);
    logic [2*FrameLen-1:0] got;
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    d          = d1;
    load_valid = 1'b1;
    for (int b = 0; b < 2 * int'(FrameLen); b++) begin
      @(negedge clk);
      if (b == 0) d = d2;
      if (b == int'(FrameLen)) load_valid = 1'b0;
      got[2*FrameLen-1-b] = sout_m;
      if (valid_m) nvalid++;
    end
    chk({nm, "_stream"}, got, exp);
    chk({nm, "_nvalid"}, 16'(nvalid), 16'(2 * FrameLen));
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{d: 4'b1011, exp_m: 4'b1011, exp_l: 4'b1101, exp_par: 1'b1};
    vecs[1] = '{d: 4'b0011, exp_m: 4'b0011, exp_l: 4'b1100, exp_par: 1'b0};
    vecs[2] = '{d: 4'b1001, exp_m: 4'b1001, exp_l: 4'b1001, exp_par: 1'b0};
    vecs[3] = '{d: 4'b0111, exp_m: 4'b0111, exp_l: 4'b1110, exp_par: 1'b1};
    vecs[4] = '{d: 4'b1110, exp_m: 4'b1110, exp_l: 4'b0111, exp_par: 1'b1};

    reset      = 1'b0;
    load_valid = 1'b0;
    d          = 4'b0000;
    #1;
    outputs_zero("rst");
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_ready", {ready_m, ready_l}, 2'b11);

    for (int i = 0; i < 5; i++) single_frame(vecs[i]);

`ifdef PISO_PARITY_EN
    two_frames("b2b", 4'b1001, 4'b1110, {4'b1001, 1'b0, 4'b1110, 1'b1});
    two_frames("hold", 4'b0111, 4'b1111, {4'b0111, 1'b1, 4'b1111, 1'b0});
`else
    two_frames("b2b", 4'b1001, 4'b1110, 8'b1001_1110);
    two_frames("hold", 4'b0111, 4'b1111, 8'b0111_1111);
`endif

    // Reset in the middle of a frame of 0011, after two bits.
    @(negedge clk);
    d          = 4'b0011;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    outputs_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ready", {ready_m, ready_l}, 2'b11);
    single_frame(vecs[0]);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
